lif_n_array: RTL

LIF_N_ARRAY -- requirements
Module: lif_n_array

---
 rtl/lif_pkg.sv | 13 +
 rtl/lif_update.sv | 38 +++
 rtl/lif_n_array.sv | 116 +++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

   localparam int LIF_WIDTH      = 8;
   localparam int LIF_LEAK_SHIFT = 1;
   localparam int LIF_REFRACT    = 2;

   // Refractory counter width; at least one bit even when refractory is disabled.
   function automatic int rf_width(input int refract);
      return (refract < 1) ? 1 : $clog2(refract + 1);
   endfunction

endpackage

// File: rtl/lif_update.sv
// Single-channel leaky integrate-and-fire update: refractory, fire, or leak+integrate.
module lif_update
   import lif_pkg::*;
#(
   parameter int WIDTH      = LIF_WIDTH,
   parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
   parameter int REFRACT    = LIF_REFRACT,
   parameter int RFW        = rf_width(REFRACT)
) (
   input  logic [WIDTH-1:0] st_in,
   input  logic [RFW-1:0]   rf_in,
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] thr,
   output logic [WIDTH-1:0] st_out,
   output logic [RFW-1:0]   rf_out,
   output logic             spike_out
);

   logic [WIDTH:0] sum;

   // NOTE: every output gets a default before the branches, so no path leaves a latch.
   always_comb begin
      sum       = {1'b0, cur} + {1'b0, WIDTH'(st_in >> LEAK_SHIFT)};
      st_out    = '0;
      rf_out    = '0;
      spike_out = 1'b0;
      if (rf_in != '0) begin
         rf_out = rf_in - RFW'(1);
      end else if (st_in >= thr) begin
         spike_out = 1'b1;
         rf_out    = RFW'(REFRACT);
      end else begin
         // The carry bit signals overflow: clamp instead of wrapping.
         st_out = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/lif_n_array.sv
// Array of LIF neurons sharing one update datapath, visited round-robin by a channel pointer.
module lif_n_array
   import lif_pkg::*;
#(
   parameter int WIDTH      = LIF_WIDTH,
   parameter int CHANNELS   = 4,
   parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
   parameter int REFRACT    = LIF_REFRACT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [CHANNELS*WIDTH-1:0]     current,
   input  logic [WIDTH-1:0]              thr,
   input  logic [$clog2(CHANNELS)-1:0]   mon_sel,
   output logic [CHANNELS-1:0]           spike,
   output logic [WIDTH-1:0]              state_mon,
   output logic                          sweep_done
);

   localparam int PW  = $clog2(CHANNELS);
   localparam int RFW = rf_width(REFRACT);

   logic [PW-1:0]       ptr_q, ptr_d;
   logic [WIDTH-1:0]    st_q [CHANNELS];
   logic [WIDTH-1:0]    st_d [CHANNELS];
   logic [RFW-1:0]      rf_q [CHANNELS];
   logic [RFW-1:0]      rf_d [CHANNELS];
   logic [CHANNELS-1:0] spike_q, spike_d;
   logic [WIDTH-1:0]    state_mon_q, state_mon_d;
   logic                sweep_done_q, sweep_done_d;

   logic [WIDTH-1:0] cur_sel, st_sel, upd_st;
   logic [RFW-1:0]   rf_sel, upd_rf;
   logic             upd_spike;

   // Operand mux for the channel under the pointer.
   always_comb begin
      cur_sel = current[int'(ptr_q)*WIDTH +: WIDTH];
      st_sel  = '0;
      rf_sel  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (int'(ptr_q) == c) begin
            st_sel = st_q[c];
            rf_sel = rf_q[c];
         end
      end
   end

   lif_update #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRACT    (REFRACT),
      .RFW        (RFW)
   ) u_update (
      .st_in     (st_sel),
      .rf_in     (rf_sel),
      .cur       (cur_sel),
      .thr       (thr),
      .st_out    (upd_st),
      .rf_out    (upd_rf),
      .spike_out (upd_spike)
   );

   always_comb begin
      ptr_d        = ptr_q;
      st_d         = st_q;
      rf_d         = rf_q;
      spike_d      = spike_q;
      sweep_done_d = 1'b0;
      if (en) begin
         sweep_done_d = (int'(ptr_q) == CHANNELS - 1);
         ptr_d        = (int'(ptr_q) == CHANNELS - 1) ? '0 : ptr_q + PW'(1);
         for (int c = 0; c < CHANNELS; c++) begin
            if (int'(ptr_q) == c) begin
               st_d[c]    = upd_st;
               rf_d[c]    = upd_rf;
               spike_d[c] = upd_spike;
            end
         end
      end
      // Out-of-range selects match no channel and read as zero.
      state_mon_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (int'(mon_sel) == c) state_mon_d = st_q[c];
      end
   end

   // NOTE: st/rf are a handful of flops, not a RAM, so clearing them on reset is cheap and required.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q        <= '0;
         spike_q      <= '0;
         state_mon_q  <= '0;
         sweep_done_q <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            st_q[c] <= '0;
            rf_q[c] <= '0;
         end
      end else begin
         ptr_q        <= ptr_d;
         spike_q      <= spike_d;
         state_mon_q  <= state_mon_d;
         sweep_done_q <= sweep_done_d;
         for (int c = 0; c < CHANNELS; c++) begin
            st_q[c] <= st_d[c];
            rf_q[c] <= rf_d[c];
         end
      end
   end

   assign spike      = spike_q;
   assign state_mon  = state_mon_q;
   assign sweep_done = sweep_done_q;

endmodule
